load_store_sequencer: RTL

- CPU-side initiator for the byte-serial memory controller's start/done protocol.
- Accepts one decoded load/store request and computes the effective address.
- Validates funct3, issues a single start pulse, and holds the address, mode and data stable until done.
- On completion it returns load data to the register-file write-back port, or flags a fault.

---
 rtl/load_store_sequencer_pkg.sv | 37 +++
 rtl/load_store_sequencer_access_check.sv | 31 +++
 rtl/load_store_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/load_store_sequencer_pkg.sv
// Shared definitions for the load/store sequencer: FUNCT3 encodings, FSM states,
// fault codes and the funct3 legality helper.
package load_store_sequencer_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_FAULT = 3'd4
  } lss_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam int unsigned TMO_W = 4;

  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_store_sequencer_access_check.sv
// Combinational access checker: illegal funct3 and (with MISALIGN_TRAP_EN defined)
// halfword/word misalignment of the effective address.
module lsu_access_check
  import load_store_sequencer_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] ea_lo,
  output logic       illegal,
  output logic       misaligned
);

  assign illegal = !funct3_legal(funct3, is_store);

`ifdef MISALIGN_TRAP_EN
  // Size comes from funct3[1:0]; illegal encodings are caught by 'illegal' first.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = ea_lo[0];
      2'b10:   misaligned = (ea_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
  logic unused_ea_lo;
  assign unused_ea_lo = ^ea_lo;
`endif

endmodule

// File: rtl/load_store_sequencer.sv
// CPU-side start/done initiator for the byte-serial memory controller.
// Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        mem_done,
  input  logic [31:0] mem_read_data,
  output logic        mem_start,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_mode,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic        busy,
  output logic        wb_enable,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  // Handshake: mem_start is a single-cycle pulse in ISSUE; the mem_* bus stays
  // stable until mem_done (a one-cycle pulse) is seen in WAIT.
  lss_state_e state_q, state_d;

  logic [31:0]      ea;
  logic [31:0]      ea_q;
  logic [2:0]       f3_q;
  logic             st_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [31:0]      rdata_q;
  logic [1:0]       code_q;
  logic [TMO_W-1:0] cnt_q;
  logic             illegal;
  logic             misaligned;
  logic             tmo_hit;
  logic             mem_active;

  assign ea      = base + imm;
  assign tmo_hit = (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  lsu_access_check u_check (
    .funct3     (funct3),
    .is_store   (is_store),
    .ea_lo      (ea[1:0]),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            ea_q    <= ea;
            f3_q    <= funct3;
            st_q    <= is_store;
            wdata_q <= store_data;
            rd_q    <= rd;
            // Illegal funct3 outranks misalignment.
            if (illegal) begin
              code_q <= FC_ILLEGAL;
            end else if (misaligned) begin
              code_q <= FC_MISALIGN;
            end
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_done) begin
            rdata_q <= mem_read_data;
          end else if (tmo_hit) begin
            code_q <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    mem_active       = 1'b0;
    mem_start        = 1'b0;
    mem_address      = '0;
    mem_mode         = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    busy             = (state_q != ST_IDLE);
    wb_enable        = 1'b0;
    wb_rd            = '0;
    wb_data          = '0;
    fault            = 1'b0;
    fault_code       = FC_NONE;
    fault_addr       = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = (illegal || misaligned) ? ST_FAULT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_active = 1'b1;
        mem_start  = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        mem_active = 1'b1;
        // A done on the expiring cycle still counts as completion.
        if (mem_done) begin
          state_d = st_q ? ST_IDLE : ST_WB;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        wb_enable = (rd_q != 5'd0);
        wb_rd     = rd_q;
        wb_data   = rdata_q;
        state_d   = ST_IDLE;
      end
      ST_FAULT: begin
        fault      = 1'b1;
        fault_code = code_q;
        fault_addr = ea_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (mem_active) begin
      mem_address      = ea_q;
      mem_mode         = f3_q;
      mem_write_enable = st_q;
      mem_write_data   = wdata_q;
    end
  end

endmodule
